// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_arbiter
// Description : Round-robin sharing of one sequential multiplier among
//               NUM_REQ requesters, with a watchdog that aborts hung operations.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int P_WIDTH = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_x,
  input  logic [NUM_REQ*WIDTH-1:0]   req_y,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [P_WIDTH-1:0]         resp_product,
  output logic                       resp_err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [WIDTH-1:0]           mul_x,
  output logic [WIDTH-1:0]           mul_y,
  output logic                       mul_start,
  input  logic                       mul_ready,
  input  logic [P_WIDTH-1:0]         mul_product
);

  localparam int                 c_ID_W      = $clog2(NUM_REQ);
  localparam int                 c_SUM_W     = c_ID_W + 1;
  localparam logic [NUM_REQ-1:0] c_ONE       = NUM_REQ'(1);
  localparam logic [7:0]         c_WDOG_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_ID_W-1:0]   r_rr;
  logic [c_ID_W-1:0]   r_grant_id;
  logic [7:0]          r_wdog;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [P_WIDTH-1:0]  r_resp_product;
  logic                r_resp_err;
  logic [WIDTH-1:0]    r_mul_x;
  logic [WIDTH-1:0]    r_mul_y;
  logic                r_mul_start;

  logic                w_found;
  logic [c_ID_W-1:0]   w_win;
  logic [c_SUM_W-1:0]  w_sum;
  logic [c_ID_W-1:0]   w_cand;
  logic                w_expired;

  // First requester at or above the rr pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr} + c_SUM_W'(i);
      if (w_sum >= c_SUM_W'(NUM_REQ)) begin
        w_sum = w_sum - c_SUM_W'(NUM_REQ);
      end
      w_cand = w_sum[c_ID_W-1:0];
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_expired = (r_wdog >= c_WDOG_LAST);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state        <= S_IDLE;
      r_rr           <= '0;
      r_grant_id     <= '0;
      r_wdog         <= '0;
      r_req_ready    <= '0;
      r_resp_valid   <= '0;
      r_resp_product <= '0;
      r_resp_err     <= 1'b0;
      r_mul_x        <= '0;
      r_mul_y        <= '0;
      r_mul_start    <= 1'b0;
    end else begin
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      r_mul_start  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found && mul_ready) begin
            r_req_ready <= c_ONE << w_win;
            r_mul_x     <= req_x[w_win*WIDTH +: WIDTH];
            r_mul_y     <= req_y[w_win*WIDTH +: WIDTH];
            r_grant_id  <= w_win;
            r_mul_start <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wdog  <= '0;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          r_wdog <= r_wdog + 8'd1;
          if (!mul_ready) begin
            r_state <= S_WAIT_DONE;
          end else if (w_expired) begin
            r_resp_product <= '0;
            r_resp_err     <= 1'b1;
            r_resp_valid   <= c_ONE << r_grant_id;
            r_state        <= S_RESP;
          end
        end
        S_WAIT_DONE: begin
          r_wdog <= r_wdog + 8'd1;
          // A completion seen on the last watchdog cycle still wins over abort.
          if (mul_ready) begin
            r_resp_product <= mul_product;
            r_resp_err     <= 1'b0;
            r_resp_valid   <= c_ONE << r_grant_id;
            r_state        <= S_RESP;
          end else if (w_expired) begin
            r_resp_product <= '0;
            r_resp_err     <= 1'b1;
            r_resp_valid   <= c_ONE << r_grant_id;
            r_state        <= S_RESP;
          end
        end
        S_RESP: begin
          r_rr       <= (r_grant_id == c_ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
          r_resp_err <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_product = r_resp_product;
  assign resp_err     = r_resp_err;
  assign grant_id     = r_grant_id;
  assign busy         = (r_state != S_IDLE);
  assign mul_x        = r_mul_x;
  assign mul_y        = r_mul_y;
  assign mul_start    = r_mul_start;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_share_arbiter
// Description : Randomized self-checking bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int PW = 4;
  localparam int TO = 31;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_x;
  logic [N*W-1:0]  req_y;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [PW-1:0]   resp_product;
  logic            resp_err;
  logic [1:0]      grant_id;
  logic            busy;
  logic [W-1:0]    mul_x;
  logic [W-1:0]    mul_y;
  logic            mul_start;
  logic            mul_ready;
  logic [PW-1:0]   mul_product;

  int vectors     = 0;
  int miscompares = 0;
  int ox[N];
  int oy[N];
  int rr_m;
  bit hang;
  int m_lat;
  int m_cnt;
  int m_p;
  int starts;

  mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .P_WIDTH(PW), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_product(resp_product), .resp_err(resp_err),
    .grant_id(grant_id), .busy(busy),
    .mul_x(mul_x), .mul_y(mul_y), .mul_start(mul_start),
    .mul_ready(mul_ready), .mul_product(mul_product)
  );

  initial forever #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck, required completion");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int rr);
    for (int k = 0; k < N; k++) begin
      if (m[(rr + k) % N]) return (rr + k) % N;
    end
    return 0;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_x[i*W +: W] = W'(ox[i]);
      req_y[i*W +: W] = W'(oy[i]);
    end
  endtask

  // One cycle: sample at negedge, then advance the multiplier model.
  task automatic tick();
    @(negedge clk_in);
    if (|resp_valid) check("no_overlap", 32'(|req_ready), 0);
    if (!rst_in) begin
      m_cnt     = 0;
      mul_ready = 1'b1;
    end else if (mul_start) begin
      starts++;
      if (!hang) begin
        mul_ready   = 1'b0;
        mul_product = PW'($urandom);
        m_p         = (int'(mul_x) * int'(mul_y)) % (1 << PW);
        m_cnt       = m_lat;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mul_ready   = 1'b1;
        mul_product = PW'(m_p);
      end
    end
  endtask

  task automatic run_txn(input int lat, input bit keep);
    int exp_w, ex, ey, cyc, exp_p;
    bit got;
    m_lat  = lat;
    exp_w  = pick(req_valid, rr_m);
    ex     = ox[exp_w];
    ey     = oy[exp_w];
    exp_p  = hang ? 0 : (ex * ey) % (1 << PW);
    starts = 0;
    got    = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = |req_ready;
    end
    check("grant_seen", 32'(got), 1);
    if (!got) return;
    check("req_ready", 32'(req_ready), 32'(1 << exp_w));
    check("grant_id", 32'(grant_id), 32'(exp_w));
    check("mul_start", 32'(mul_start), 1);
    check("mul_x", 32'(mul_x), 32'(ex));
    check("mul_y", 32'(mul_y), 32'(ey));
    if (!keep) begin
      req_valid[exp_w] = 1'b0;
      ox[exp_w]        = ex ^ 2;
      drive_ops();
    end
    cyc = 0;
    got = 0;
    while (!got && cyc < TO + 10) begin
      tick();
      cyc++;
      got = |resp_valid;
    end
    check("resp_seen", 32'(got), 1);
    if (!got) return;
    check("resp_valid", 32'(resp_valid), 32'(1 << exp_w));
    check("resp_product", 32'(resp_product), 32'(exp_p));
    check("resp_err", 32'(resp_err), 32'(hang));
    check("latency", 32'(cyc), hang ? 32'(TO + 1) : 32'(lat + 1));
    check("start_count", 32'(starts), 1);
    check("mul_x_held", 32'(mul_x), 32'(ex));
    rr_m = (exp_w + 1) % N;
    tick();
    check("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    bit got;
    rst_in      = 1'b0;
    req_valid   = '0;
    mul_ready   = 1'b1;
    mul_product = '0;
    hang        = 1'b0;
    m_cnt       = 0;
    m_lat       = 2;
    rr_m        = 0;
    for (int i = 0; i < N; i++) begin
      ox[i] = 0;
      oy[i] = 0;
    end
    drive_ops();
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_mul_start", 32'(mul_start), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_product", 32'(resp_product), 0);
    rst_in = 1'b1;
    tick();

    // Fairness: all four held, served 0,1,2,3,0.
    for (int i = 0; i < N; i++) begin
      ox[i] = i + 1;
      oy[i] = 2;
    end
    drive_ops();
    req_valid = 4'b1111;
    repeat (5) run_txn(2, 1'b1);
    req_valid = '0;

    // Single request 3*2.
    ox[0] = 3; oy[0] = 2;
    drive_ops();
    req_valid = 4'b0001;
    run_txn(2, 1'b0);

    // Wrap: winner 3, then 1001 gives 0 then 3.
    ox[3] = 2; oy[3] = 3;
    drive_ops();
    req_valid = 4'b1000;
    run_txn(3, 1'b0);
    req_valid = 4'b1001;
    run_txn(2, 1'b0);
    run_txn(4, 1'b0);

    // Operand change after grant: x goes 5 -> 7 once accepted.
    ox[1] = 5; oy[1] = 3;
    drive_ops();
    req_valid = 4'b0010;
    run_txn(2, 1'b0);

    // Hung multiplier, then a normal transaction.
    hang = 1'b1;
    ox[2] = 3; oy[2] = 3;
    drive_ops();
    req_valid = 4'b0100;
    run_txn(2, 1'b0);
    hang = 1'b0;
    req_valid = 4'b0100;
    run_txn(2, 1'b0);

    // Reset during WAIT_DONE.
    req_valid = 4'b0001;
    m_lat  = 5;
    got    = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = |req_ready;
    end
    check("rst_test_grant", 32'(got), 1);
    req_valid = '0;
    repeat (2) tick();
    rst_in = 1'b0;
    #1;
    check("async_busy", 32'(busy), 0);
    check("async_mul_start", 32'(mul_start), 0);
    check("async_grant_id", 32'(grant_id), 0);
    check("async_mul_x", 32'(mul_x), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("no_resp_in_rst", 32'(resp_valid), 0);
    end
    rst_in = 1'b1;
    rr_m   = 0;
    ox[2] = 4; oy[2] = 3;
    drive_ops();
    req_valid = 4'b0100;
    run_txn(2, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          ox[i] = int'($urandom_range(0, (1 << W) - 1));
          oy[i] = int'($urandom_range(0, (1 << W) - 1));
        end
      end
      if (req_valid == '0) begin
        req_valid[$urandom_range(0, N - 1)] = 1'b1;
      end
      drive_ops();
      hang = ($urandom_range(0, 9) == 0);
      run_txn(int'($urandom_range(2, 5)), 1'($urandom_range(0, 1)));
      hang = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one sequential multiplier (start/ready handshake, x/y operands, product result) among NUM_REQ requesters. Grants are round-robin. The block latches the winner's operands, sequences the multiplier through start, accept and completion, then returns the product to the winner with a one-cycle response pulse. A watchdog aborts a hung multiplier transaction.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 4, operand width per requester
P_WIDTH, 4, multiplier product width (product truncated by multiplier, passed through unchanged)
TIMEOUT, 31, max cycles spent in WAIT_ACK+WAIT_DONE before abort (1..255)

Ports:
clk_in  input  1  single clock, rising edge
rst_in  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester request level; held until req_ready seen
req_x  input  NUM_REQ*WIDTH  packed operands x, requester i at [i*WIDTH +: WIDTH]
req_y  input  NUM_REQ*WIDTH  packed operands y, same packing
req_ready  output  NUM_REQ  one-hot one-cycle grant/accept pulse
resp_valid  output  NUM_REQ  one-hot one-cycle response pulse to winner
resp_product  output  P_WIDTH  product, valid only while resp_valid nonzero
resp_err  output  1  high with resp_valid when transaction aborted by watchdog
grant_id  output  $clog2(NUM_REQ)  index of current/last winner
busy  output  1  high in any state except IDLE
mul_x  output  WIDTH  operand x to multiplier (registered)
mul_y  output  WIDTH  operand y to multiplier (registered)
mul_start  output  1  one-cycle start pulse to multiplier
mul_ready  input  1  multiplier idle/done level
mul_product  input  P_WIDTH  multiplier result

Behaviour:
- Reset (rst_in low, async): state IDLE; all outputs 0; rr pointer 0; watchdog 0. Takes effect mid-transaction immediately: mul_start drops, no resp_valid issued for the aborted request, requester must re-request.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP.
- IDLE: if req_valid != 0 and mul_ready == 1, pick the winner. Winner = first set bit scanning from rr pointer upward with wrap. That cycle, pulse req_ready[winner], latch req_x/req_y slices into mul_x/mul_y, set grant_id, go to ISSUE. If mul_ready == 0, no grant, stay IDLE.
- ISSUE: mul_start = 1 for exactly this cycle; go to WAIT_ACK; watchdog cleared.
- WAIT_ACK: wait for mul_ready == 0 (multiplier accepted), then go to WAIT_DONE.
- WAIT_DONE: wait for mul_ready == 1, capture mul_product into resp_product register, then go to RESP.
- Watchdog increments each cycle in WAIT_ACK/WAIT_DONE. On reaching TIMEOUT, go to RESP with resp_err = 1 and resp_product = 0.
- RESP: resp_valid[grant_id] = 1 for one cycle, resp_err as set. rr pointer = (grant_id+1) mod NUM_REQ. Return to IDLE.
- Minimum turnaround: grant to resp_valid = 4 cycles with a multiplier that drops ready 1 cycle after start and raises it 1 cycle later. Back-to-back grant possible the cycle after RESP (IDLE).
- mul_x/mul_y hold latched values from grant until next grant; requester operands may change after req_ready.
- Requests are sampled only in IDLE. req_valid changes in other states are ignored. A request dropped before grant is simply not served.
- Simultaneous requests: exactly one grant per transaction. Every continuously asserted requester is served within NUM_REQ transactions.
- req_ready and resp_valid are never asserted in the same cycle. At most one bit set in each.
- mul_ready == 1 in WAIT_ACK is not an error; keep waiting (watchdog bounds it).

Test Plan:
- Single request: req_valid=0001, x0=3, y0=2, multiplier model drops ready 1 cycle after start, returns after 3 cycles -> req_ready=0001 one cycle, one mul_start pulse with mul_x=3, mul_y=2, resp_valid=0001 with resp_product=6, resp_err=0, busy back low.
- Contention/fairness: req_valid=1111 held, operands xi=i+1, yi=2 -> grants in order 0,1,2,3,0; products 2,4,6,8; each resp_valid goes only to its winner.
- Round-robin wrap: last winner 3, req_valid=1001 -> next grant to 0, then 3.
- Operand change after grant: requester 1 changes x from 5 to 7 the cycle after req_ready -> mul_x stays 5, product reflects 5*y.
- Hung multiplier: mul_ready stuck 1 after start with TIMEOUT=31 -> after 31 cycles in the wait states, resp_valid to winner with resp_err=1, resp_product=0. Next request proceeds normally.
- Reset mid-op: assert rst_in low in WAIT_DONE -> all outputs 0 asynchronously, no resp_valid. After release with req_valid=0100, the grant goes to 2 (rr pointer 0, scan up).
